// File: rtl/delta_demodulator.sv
// delta_demodulator
//   Rebuilds a WIDTH-bit sample from an up/down spike stream. Each up spike
//   adds the step size, each down spike subtracts it. The result saturates at
//   the rails, and sticky flags record each clamp. A load input forces the
//   accumulator to a given value. An optional idle leak decays the sample by 1
//   toward zero after LEAK_PERIOD consecutive idle cycles.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   spike[1:0]   [1] up spike, [0] down spike
//   threshold    unsigned step size per spike
//   load         force accumulator to load_value
//   load_value   value forced by load
//   clear_flags  clear sat_hi / sat_lo
//   recon        reconstructed sample
//   recon_valid  one-cycle pulse when recon changed value
//   sat_hi       sticky: an up step clamped at the top rail
//   sat_lo       sticky: a down step clamped at zero
module delta_demodulator #(
  parameter int WIDTH       = 4,
  parameter int LEAK_PERIOD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       spike,
  input  logic [WIDTH-1:0] threshold,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] recon,
  output logic             recon_valid,
  output logic             sat_hi,
  output logic             sat_lo
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [7:0]       LEAK_P  = 8'(LEAK_PERIOD);

  // stage-1 input registers
  logic [1:0]       spike_s1_q, spike_s1_d;
  logic [WIDTH-1:0] threshold_s1_q, threshold_s1_d;
  logic             load_s1_q, load_s1_d;
  logic [WIDTH-1:0] load_value_s1_q, load_value_s1_d;
  logic             clear_s1_q, clear_s1_d;

  // accumulator state
  logic [WIDTH-1:0] recon_q, recon_d;
  logic             recon_valid_q, recon_valid_d;
  logic             sat_hi_q, sat_hi_d;
  logic             sat_lo_q, sat_lo_d;
  logic [7:0]       leak_cnt_q, leak_cnt_d;

  logic [WIDTH:0]   sum;
  logic [8:0]       leak_inc;
  logic             set_hi, set_lo;

  always_comb begin
    spike_s1_d      = spike;
    threshold_s1_d  = threshold;
    load_s1_d       = load;
    load_value_s1_d = load_value;
    clear_s1_d      = clear_flags;

    recon_d    = recon_q;
    leak_cnt_d = leak_cnt_q;
    set_hi     = 1'b0;
    set_lo     = 1'b0;
    sum        = {1'b0, recon_q} + {1'b0, threshold_s1_q};
    leak_inc   = {1'b0, leak_cnt_q} + 9'd1;

    if (load_s1_q) begin
      recon_d    = load_value_s1_q;
      leak_cnt_d = '0;
    end else begin
      unique case (spike_s1_q)
        2'b10: begin
          leak_cnt_d = '0;
          // carry out of the WIDTH+1 bit sum means the true result exceeds the rail
          if (sum[WIDTH]) begin
            recon_d = MAX_VAL;
            set_hi  = 1'b1;
          end else begin
            recon_d = sum[WIDTH-1:0];
          end
        end
        2'b01: begin
          leak_cnt_d = '0;
          if (threshold_s1_q > recon_q) begin
            recon_d = '0;
            set_lo  = 1'b1;
          end else begin
            recon_d = recon_q - threshold_s1_q;
          end
        end
        2'b11: leak_cnt_d = '0;
        default: begin
          if (LEAK_PERIOD != 0) begin
            if (leak_inc >= {1'b0, LEAK_P}) begin
              // at zero the counter parks at the period so the next idle
              // cycle after a load/step starts a fresh count from activity
              if (recon_q != '0) begin
                recon_d    = recon_q - ONE;
                leak_cnt_d = '0;
              end else begin
                leak_cnt_d = LEAK_P;
              end
            end else begin
              leak_cnt_d = leak_inc[7:0];
            end
          end
        end
      endcase
    end

    // a clamp in the same cycle as clear_flags wins over the clear
    sat_hi_d = clear_s1_q ? 1'b0 : sat_hi_q;
    sat_lo_d = clear_s1_q ? 1'b0 : sat_lo_q;
    if (set_hi) sat_hi_d = 1'b1;
    if (set_lo) sat_lo_d = 1'b1;

    recon_valid_d = (recon_d != recon_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spike_s1_q      <= '0;
      threshold_s1_q  <= '0;
      load_s1_q       <= 1'b0;
      load_value_s1_q <= '0;
      clear_s1_q      <= 1'b0;
      recon_q         <= '0;
      recon_valid_q   <= 1'b0;
      sat_hi_q        <= 1'b0;
      sat_lo_q        <= 1'b0;
      leak_cnt_q      <= '0;
    end else begin
      spike_s1_q      <= spike_s1_d;
      threshold_s1_q  <= threshold_s1_d;
      load_s1_q       <= load_s1_d;
      load_value_s1_q <= load_value_s1_d;
      clear_s1_q      <= clear_s1_d;
      recon_q         <= recon_d;
      recon_valid_q   <= recon_valid_d;
      sat_hi_q        <= sat_hi_d;
      sat_lo_q        <= sat_lo_d;
      leak_cnt_q      <= leak_cnt_d;
    end
  end

  assign recon       = recon_q;
  assign recon_valid = recon_valid_q;
  assign sat_hi      = sat_hi_q;
  assign sat_lo      = sat_lo_q;

endmodule

// File: tb/tb_delta_demodulator.sv
// tb_delta_demodulator
//   Directed scenarios plus randomized spike traffic for delta_demodulator
//   (WIDTH=4, LEAK_PERIOD=4), checked every cycle against an integer model.
module tb_delta_demodulator;

  localparam int WIDTH = 4;
  localparam int LEAK  = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       spike = '0;
  logic [WIDTH-1:0] threshold = '0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_value = '0;
  logic             clear_flags = 1'b0;
  logic [WIDTH-1:0] recon;
  logic             recon_valid;
  logic             sat_hi;
  logic             sat_lo;

  delta_demodulator #(.WIDTH(WIDTH), .LEAK_PERIOD(LEAK)) dut (
    .clk(clk), .rst_n(rst_n), .spike(spike), .threshold(threshold),
    .load(load), .load_value(load_value), .clear_flags(clear_flags),
    .recon(recon), .recon_valid(recon_valid), .sat_hi(sat_hi), .sat_lo(sat_lo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // reference model: one delayed input set, integer accumulator
  int m_recon, m_valid, m_hi, m_lo, m_idle;
  int p_sp, p_th, p_ld, p_lv, p_clr;

  task automatic model_edge(input int rst, input int sp, input int th,
                            input int ld, input int lv, input int clr);
    int nr;
    bit shi, slo;
    if (rst == 0) begin
      m_recon = 0; m_valid = 0; m_hi = 0; m_lo = 0; m_idle = 0;
      p_sp = 0; p_th = 0; p_ld = 0; p_lv = 0; p_clr = 0;
      return;
    end
    nr = m_recon; shi = 0; slo = 0;
    if (p_ld != 0) begin
      nr = p_lv; m_idle = 0;
    end else if (p_sp == 2) begin
      m_idle = 0;
      if (m_recon + p_th > MAXV) begin nr = MAXV; shi = 1; end
      else nr = m_recon + p_th;
    end else if (p_sp == 1) begin
      m_idle = 0;
      if (p_th > m_recon) begin nr = 0; slo = 1; end
      else nr = m_recon - p_th;
    end else if (p_sp == 3) begin
      m_idle = 0;
    end else begin
      m_idle = (m_idle + 1 > LEAK) ? LEAK : m_idle + 1;
      if (m_idle == LEAK && m_recon != 0) begin
        nr = m_recon - 1; m_idle = 0;
      end
    end
    if (p_clr != 0) begin m_hi = 0; m_lo = 0; end
    if (shi) m_hi = 1;
    if (slo) m_lo = 1;
    m_valid = (nr != m_recon) ? 1 : 0;
    m_recon = nr;
    p_sp = sp; p_th = th; p_ld = ld; p_lv = lv; p_clr = clr;
  endtask

  task automatic step(input int rst, input int sp, input int th,
                      input int ld, input int lv, input int clr);
    @(negedge clk);
    rst_n       = rst[0];
    spike       = 2'(sp);
    threshold   = 4'(th);
    load        = ld[0];
    load_value  = 4'(lv);
    clear_flags = clr[0];
    @(posedge clk);
    model_edge(rst, sp, th, ld, lv, clr);
    #1;
    chk("recon", int'(recon), m_recon);
    chk("recon_valid", int'(recon_valid), m_valid);
    chk("sat_hi", int'(sat_hi), m_hi);
    chk("sat_lo", int'(sat_lo), m_lo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int r, sp, th, ld, clr, rst;

    // reset
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_recon", int'(recon), 0);
    chk("rst_valid", int'(recon_valid), 0);
    chk("rst_flags", int'({sat_hi, sat_lo}), 0);

    // three up spikes, threshold 3 -> 3, 6, 9
    step(1, 2, 3, 0, 0, 0); chk("t1_lat", int'(recon), 0);
    step(1, 2, 3, 0, 0, 0); chk("t1_a", int'(recon), 3); chk("t1_va", int'(recon_valid), 1);
    step(1, 2, 3, 0, 0, 0); chk("t1_b", int'(recon), 6); chk("t1_vb", int'(recon_valid), 1);
    step(1, 0, 3, 0, 0, 0); chk("t1_c", int'(recon), 9); chk("t1_vc", int'(recon_valid), 1);
    chk("t1_flags", int'({sat_hi, sat_lo}), 0);

    // load 14, up by 5 clamps at 15, second up stays at the rail
    step(1, 0, 0, 1, 14, 0);
    step(1, 2, 5, 0, 0, 0); chk("t2_load", int'(recon), 14);
    step(1, 2, 5, 0, 0, 0); chk("t2_clamp", int'(recon), 15); chk("t2_hi", int'(sat_hi), 1);
    chk("t2_v", int'(recon_valid), 1);
    step(1, 0, 0, 0, 0, 0); chk("t2_rail", int'(recon), 15); chk("t2_v0", int'(recon_valid), 0);
    chk("t2_hi2", int'(sat_hi), 1);

    // exact boundary: at 15, up with threshold 0 must not flag
    step(1, 0, 0, 0, 0, 1);
    step(1, 2, 0, 0, 0, 0); chk("bnd_hi_clr", int'(sat_hi), 0);
    step(1, 0, 0, 0, 0, 0); chk("bnd_recon", int'(recon), 15); chk("bnd_hi", int'(sat_hi), 0);

    // recon 2, down by 4 with clear_flags in the same cycle -> sat_lo set
    step(1, 0, 0, 1, 2, 0);
    step(1, 1, 4, 0, 0, 1); chk("t3_load", int'(recon), 2);
    step(1, 0, 0, 0, 0, 1); chk("t3_clamp", int'(recon), 0); chk("t3_lo", int'(sat_lo), 1);
    step(1, 0, 0, 0, 0, 0); chk("t3_clr", int'(sat_lo), 0);

    // load beats a simultaneous double spike; double spike alone is no-op
    step(1, 0, 0, 1, 6, 0);
    step(1, 3, 2, 1, 9, 0); chk("t4_six", int'(recon), 6);
    step(1, 3, 2, 0, 0, 0); chk("t4_load", int'(recon), 9);
    step(1, 0, 0, 0, 0, 0); chk("t4_both", int'(recon), 9); chk("t4_v0", int'(recon_valid), 0);

    // leak: load 3 then 20 idle cycles -> 2, 1, 0 after idle 4, 8, 12
    step(1, 0, 0, 1, 3, 0);
    for (int j = 1; j <= 20; j++) begin
      step(1, 0, 0, 0, 0, 0);
      chk("t5_leak", int'(recon), (j < 5) ? 3 : (j < 9) ? 2 : (j < 13) ? 1 : 0);
    end

    // up spike with zero step mid-leak restarts the idle count
    step(1, 0, 0, 1, 5, 0);
    idle(3);
    step(1, 2, 0, 0, 0, 0);
    idle(4); chk("t5_restart", int'(recon), 5);
    idle(1); chk("t5_after", int'(recon), 4);

    // reset discards an in-flight spike
    step(1, 2, 5, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("t6_recon", int'(recon), 0);
    chk("t6_valid", int'(recon_valid), 0);
    chk("t6_flags", int'({sat_hi, sat_lo}), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r   = int'($urandom_range(0, 199));
      rst = (r == 0) ? 0 : 1;
      sp  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      th  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, MAXV));
      ld  = ($urandom_range(0, 19) == 0) ? 1 : 0;
      clr = ($urandom_range(0, 9) == 0) ? 1 : 0;
      step(rst, sp, th, ld, int'($urandom_range(0, MAXV)), clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/delta_demodulator.md
Name: delta_demodulator

Overview:
- Receive-side counterpart of the delta-modulation spike encoder: reconstructs a WIDTH-bit sample from its up/down spike stream.
- Each up spike adds the step size to an accumulator and each down spike subtracts it, using the same threshold the encoder was configured with.
- Sits downstream of the encoder, or on a separate die fed from the encoder's spike pins.
- Adds saturation, sticky saturation flags, a forced-load path and an optional idle leak toward zero.

Parameters:
- WIDTH, 4, width of threshold, load value and reconstructed sample.
- LEAK_PERIOD, 0, number of consecutive idle input cycles before the accumulator decays by 1 toward 0. 0 disables leak. Legal range 0..255.

Ports:
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  synchronous active-low reset
- spike  input  2  spike[1] = up (on) spike, spike[0] = down (off) spike
- threshold  input  WIDTH  step size per spike, unsigned
- load  input  1  force accumulator to load_value
- load_value  input  WIDTH  value forced by load
- clear_flags  input  1  clears sat_hi/sat_lo
- recon  output  WIDTH  reconstructed sample
- recon_valid  output  1  one-cycle pulse: recon changed value this cycle
- sat_hi  output  1  sticky: an up step clamped at 2^WIDTH-1
- sat_lo  output  1  sticky: a down step clamped at 0

Behaviour:
- Input stage: spike, threshold, load, load_value and clear_flags are registered every edge into stage-1 registers.
- All accumulator decisions use stage-1 values. Latency is 2 edges: inputs present before edge k are reflected on recon after edge k+1.
- Reset (rst_n low at an edge):
  - stage-1 registers, recon, recon_valid, sat_hi, sat_lo and the leak counter all go to 0;
  - an in-flight spike in stage 1 is discarded;
  - reset mid-stream takes effect at that edge and has priority over everything.
- Accumulator update priority, evaluated each edge from stage-1 values:
  1. load: recon <= load_value. Leak counter cleared. Spikes that cycle are ignored.
  2. up only: sum = recon + threshold, computed at WIDTH+1 bits. If sum > 2^WIDTH-1, recon <= 2^WIDTH-1 and sat_hi <= 1; else recon <= sum.
  3. down only: if threshold > recon, recon <= 0 and sat_lo <= 1; else recon <= recon - threshold.
  4. both up and down: no net change, no flag. Counts as activity (leak counter cleared).
  5. neither: idle. Leak counter increments, saturating at LEAK_PERIOD. When it reaches LEAK_PERIOD and recon != 0, recon decrements by 1 and the counter restarts from 0. When recon == 0 the counter holds.
- Any spike or load clears the leak counter. With LEAK_PERIOD=0 the leak logic is inert and recon holds indefinitely.
- threshold == 0: spikes cause no change and no saturation flag (0 + 0 never exceeds max; 0 > recon is never true).
- Exact boundary: recon=15, threshold=0, up → no change, sat_hi stays clear. Clamping only flags when the true result is out of range.
- recon_valid: 1 for exactly one cycle after any edge where recon's new value differs from its old value (load, step, clamp or leak). Load of the current value, or a clamped step already at the rail, gives recon_valid=0.
- Flags:
  - set has priority over clear when clear_flags and a saturation event coincide in stage 1;
  - otherwise clear_flags zeroes both flags at that edge;
  - flags are never cleared by load.
- No backpressure: the block accepts one spike pair per cycle unconditionally.

Test Plan:
- Reset then 3 up spikes on consecutive cycles, threshold=3 → recon 3, 6, 9 starting 2 edges after the first spike. recon_valid high each of those 3 cycles, flags 0.
- load_value=14 via load, then up spike, threshold=5 → recon 14 then 15. sat_hi=1, recon_valid=1. Second up spike → recon stays 15, recon_valid=0, sat_hi stays 1.
- recon=2, down spike with threshold=4 → recon=0, sat_lo=1. Same cycle as clear_flags → sat_lo still 1. clear_flags alone next → sat_lo=0.
- recon=6, spike=2'b11 and load=1 with load_value=9 in the same cycle → recon=9 (load wins). Then spike=2'b11 alone → recon stays 9, recon_valid=0.
- LEAK_PERIOD=4, recon=3, inputs idle for 20 cycles → recon 2, 1, 0 after the 4th, 8th and 12th idle stage-1 cycles, then holds 0. An up spike mid-leak restarts the 4-cycle count.
- Up spike presented, rst_n pulled low at the next edge → the spike never appears. recon=0, flags=0, recon_valid=0 on the first cycle out of reset.
